mmio_console: RTL and testbench

- Synthesizable memory-mapped console peripheral that snoops the core's data-memory write bus (memwrite/dataadr/writedata).
- Gives each of NUM_CH console channels its own byte FIFO, and drains all channels through one round-robin valid/ready byte stream toward a host or simulation printer.
- Generalises the single fixed console address 0x0000FFFC to multiple buffered channels with backpressure and overflow tracking.

---
 rtl/console_pkg.sv | 14 +
 rtl/mmio_console_fifo.sv | 55 +++++
 rtl/mmio_console.sv | 148 ++++++++++++++
 tb/tb_mmio_console.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared constants, byte type and address helper for the MMIO console peripheral.
package console_pkg;

  localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'h0000FFFC;
  localparam logic [31:0] EXIT_ADDR_DEFAULT    = 32'h0000FFE0;

  typedef logic [7:0] console_byte_t;

  // Channels are laid out downward from the base address, one word apart.
  function automatic logic [31:0] ch_addr(input logic [31:0] base, input int unsigned c);
    return base - (c << 2);
  endfunction

endpackage

// File: rtl/mmio_console_fifo.sv
// Per-channel byte FIFO with an extra pointer bit for full detection; exposes the head and the
// entry behind it so the arbiter can reload in the same edge as a pop.
module mmio_console_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [WIDTH-1:0]           head2_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [AW-1:0]    rd_next;
  logic             pop_ok, push_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;

  // A push while full is only legal when the head leaves in the same edge.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  assign rd_next = rd_q[AW-1:0] + AW'(1);
  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign head2_o = mem_q[rd_next];

  assign wr_d = push_ok ? wr_q + (AW+1)'(1) : wr_q;
  assign rd_d = pop_ok  ? rd_q + (AW+1)'(1) : rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped console: snoops core stores into per-channel FIFOs and drains them round-robin
// over one byte stream. Optional exit register enabled by MMIO_CONSOLE_EXIT_EN.
module mmio_console
  import console_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter int                NUM_CH       = 1,
  parameter int                FIFO_DEPTH   = 16,
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR = ADDR_W'(CONSOLE_ADDR_DEFAULT),
  parameter logic [ADDR_W-1:0] EXIT_ADDR    = ADDR_W'(EXIT_ADDR_DEFAULT),
  localparam int               CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [7:0]        out_data,
  output logic [NUM_CH-1:0] overflow,
  output logic [NUM_CH-1:0] fifo_empty,
  output logic              sim_done,
  output logic              sim_pass
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [NUM_CH-1:0] hit, pop, full, empty, avail;
  console_byte_t     head [NUM_CH];
  console_byte_t     head2[NUM_CH];
  console_byte_t     cand [NUM_CH];
  logic [AW:0]       count[NUM_CH];

  logic              valid_q, valid_d;
  logic [CH_W-1:0]   ch_q, ch_d, rr_q, rr_d, start;
  console_byte_t     data_q, data_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic              xfer;

  // out_valid/out_data/out_ch are registered copies of the granted FIFO head; the entry stays
  // in its FIFO until out_valid && out_ready at a rising edge, and nothing changes while stalled.
  assign xfer = valid_q && out_ready;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return CH_W'((int'(c) + 1) % NUM_CH);
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [ADDR_W-1:0] ADDR_C = ADDR_W'(ch_addr(32'(CONSOLE_ADDR), c));

    assign hit[c] = memwrite && (dataadr == ADDR_C);
    assign pop[c] = xfer && (ch_q == CH_W'(c));

    mmio_console_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (hit[c]),
      .pop_i   (pop[c]),
      .wdata_i (writedata[7:0]),
      .head_o  (head[c]),
      .head2_o (head2[c]),
      .count_o (count[c]),
      .full_o  (full[c]),
      .empty_o (empty[c])
    );

    // What the channel's head will be after this edge, including a store landing in an empty FIFO.
    assign avail[c] = pop[c] ? ((count[c] > (AW+1)'(1)) || hit[c]) : (!empty[c] || hit[c]);
    assign cand[c]  = pop[c] ? ((count[c] > (AW+1)'(1)) ? head2[c] : writedata[7:0])
                             : (!empty[c] ? head[c] : writedata[7:0]);
  end

  assign ovf_d = ovf_q | (hit & full & ~pop);

  always_comb begin
    valid_d = valid_q;
    ch_d    = ch_q;
    data_d  = data_q;
    rr_d    = rr_q;
    start   = rr_q;
    if (xfer) begin
      valid_d = 1'b0;
      rr_d    = next_ch(ch_q);
      start   = next_ch(ch_q);
    end
    if (!valid_q || xfer) begin
      // Scan downward so the channel closest to start is the last (winning) assignment.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (avail[(int'(start) + k) % NUM_CH]) begin
          valid_d = 1'b1;
          ch_d    = CH_W'((int'(start) + k) % NUM_CH);
          data_d  = cand[(int'(start) + k) % NUM_CH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
      data_q  <= '0;
      rr_q    <= '0;
      ovf_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_ch     = ch_q;
  assign out_data   = data_q;
  assign overflow   = ovf_q;
  assign fifo_empty = empty;

`ifdef MMIO_CONSOLE_EXIT_EN
  logic done_q, pass_q;
  logic exit_hit;

  assign exit_hit = memwrite && (dataadr == EXIT_ADDR) && !done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else if (exit_hit) begin
      done_q <= 1'b1;
      pass_q <= (writedata == '0);
    end
  end

  assign sim_done = done_q;
  assign sim_pass = pass_q;
`else
  logic unused_exit;
  assign unused_exit = ^{writedata[DATA_W-1:8], EXIT_ADDR};
  assign sim_done    = 1'b0;
  assign sim_pass    = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_console.sv
// Self-checking bench for mmio_console: directed scenarios then random stores, all compared
// against a queue-based behavioural model of the console.
`timescale 1ns/100ps
module tb_mmio_console;

  localparam int NCH   = 3;
  localparam int DEPTH = 4;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [7:0]  out_data;
  logic [2:0]  overflow;
  logic [2:0]  fifo_empty;
  logic        sim_done;
  logic        sim_pass;

  always #5 clk = ~clk;

  mmio_console #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_data   (out_data),
    .overflow   (overflow),
    .fifo_empty (fifo_empty),
    .sim_done   (sim_done),
    .sim_pass   (sim_pass)
  );

  // scoreboard: one expected byte queue per channel plus the presented byte
  logic [7:0] exp_q [NCH][$];
  bit         m_valid;
  int         m_ch;
  logic [7:0] m_data;
  int         m_rr;
  logic [2:0] m_ovf;
  bit         m_done;
  bit         m_pass;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) exp_q[c].delete();
    m_valid = 0;
    m_ch    = 0;
    m_data  = 8'h00;
    m_rr    = 0;
    m_ovf   = '0;
    m_done  = 0;
    m_pass  = 0;
  endtask

  // One rising edge of the console, described as byte queues.
  task automatic model_step();
    bit found;
    if (m_valid && out_ready) begin
      void'(exp_q[m_ch].pop_front());
      m_rr    = (m_ch + 1) % NCH;
      m_valid = 0;
    end
    if (memwrite) begin
      for (int c = 0; c < NCH; c++) begin
        if (dataadr == 32'h0000FFFC - 32'(4 * c)) begin
          if (exp_q[c].size() < DEPTH) exp_q[c].push_back(writedata[7:0]);
          else m_ovf[c] = 1'b1;
        end
      end
`ifdef MMIO_CONSOLE_EXIT_EN
      if (dataadr == 32'h0000FFE0 && !m_done) begin
        m_done = 1;
        m_pass = (writedata == 32'd0);
      end
`endif
    end
    if (!m_valid) begin
      found = 0;
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m_rr + k) % NCH;
        if (!found && exp_q[c].size() > 0) begin
          found   = 1;
          m_valid = 1;
          m_ch    = c;
          m_data  = exp_q[c][0];
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [2:0] e;
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_ch", out_ch, m_ch);
      check("out_data", out_data, m_data);
    end
    check("overflow", overflow, m_ovf);
    for (int c = 0; c < NCH; c++) e[c] = (exp_q[c].size() == 0);
    check("fifo_empty", fifo_empty, e);
    check("sim_done", sim_done, m_done);
    check("sim_pass", sim_pass, m_pass);
  endtask

  // driver: called just after a falling edge; returns just after the next falling edge
  task automatic cycle(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rdy);
    memwrite  = we;
    dataadr   = a;
    writedata = d;
    out_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, rdy);
  endtask

  // Short asynchronous reset pulse between clock edges.
  task automatic reset_pulse();
    memwrite = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #0.5;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_ch", out_ch, 2'd0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_fifo_empty", fifo_empty, 3'b111);
    check("rst_overflow", overflow, 3'b000);
    #0.5 reset = 1'b1;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 7))
      0, 1:    return 32'h0000FFFC;
      2:       return 32'h0000FFF8;
      3:       return 32'h0000FFF4;
      4:       return 32'h0000FFF0;
      5:       return 32'h0000FFE0;
      6:       return 32'h0000FFFD;
      default: return 32'h0001FFFC;
    endcase
  endfunction

  initial begin
    int thresh;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_ch", out_ch, 2'd0);
    check("reset_out_data", out_data, 8'h00);
    check("reset_fifo_empty", fifo_empty, 3'b111);
    check("reset_overflow", overflow, 3'b000);
    check("reset_sim_done", sim_done, 1'b0);
    reset = 1'b1;
    idle(2, 1'b1);

    // single byte with consumer always ready
    cycle(1'b1, 32'h0000FFFC, 32'h41, 1'b1);
    check("single_valid", out_valid, 1'b1);
    check("single_data", out_data, 8'h41);
    idle(3, 1'b1);
    check("single_drained", fifo_empty, 3'b111);

    // backpressure on "HI"
    cycle(1'b1, 32'h0000FFFC, 32'h48, 1'b0);
    cycle(1'b1, 32'h0000FFFC, 32'h49, 1'b0);
    idle(10, 1'b0);
    check("bp_hold", out_data, 8'h48);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    check("bp_second", out_data, 8'h49);
    idle(3, 1'b1);

    // overflow: five stores into a depth-4 FIFO, then drain
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0000FFFC, 32'h61 + i, 1'b0);
    check("ovf_set", overflow, 3'b001);
    idle(6, 1'b1);

    // push at full together with a pop of the same channel
    reset_pulse();
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h0000FFFC, 32'h70 + i, 1'b0);
    cycle(1'b1, 32'h0000FFFC, 32'hAA, 1'b1);
    check("full_pop_push_ovf", overflow, 3'b000);
    idle(6, 1'b1);

    // round robin across three channels
    reset_pulse();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 2; i++) cycle(1'b1, 32'h0000FFFC - 32'(4 * c), 32'h30 + 2 * c + i, 1'b0);
    idle(8, 1'b1);

    // reset while bytes are buffered
    cycle(1'b1, 32'h0000FFFC, 32'h11, 1'b0);
    cycle(1'b1, 32'h0000FFF8, 32'h22, 1'b0);
    cycle(1'b1, 32'h0000FFF4, 32'h33, 1'b0);
    reset_pulse();
    idle(4, 1'b1);

    // exit register
    cycle(1'b1, 32'h0000FFE0, 32'd0, 1'b0);
    cycle(1'b1, 32'h0000FFE0, 32'd5, 1'b0);
    idle(2, 1'b1);

    // randomized traffic with changing consumer readiness
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) thresh = $urandom_range(1, 9);
      if ($urandom_range(0, 299) == 0) reset_pulse();
      cycle($urandom_range(0, 1) == 1, pick_addr(), $urandom, $urandom_range(0, 9) < thresh);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
